// File: rtl/pc_pkg.sv
// Shared definitions for the PC / history unit: default geometry,
// index-width helpers and the PC word type.
package pc_pkg;

    localparam int          DEF_WIDTH    = 32;
    localparam int          DEF_DEPTH    = 4;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

    // Bits needed to index DEPTH entries (at least one bit).
    function automatic int idx_w(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

    // Bits needed to hold an occupancy count of 0..DEPTH.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    typedef logic [DEF_WIDTH-1:0] pc_t;

endpackage

// File: rtl/pc_hist_buf.sv
// Shift-register history of past PC values. Entry 0 is the newest.
// Pushing while full drops the oldest entry. Flush clears all entries.
module pc_hist_buf
    import pc_pkg::*;
#(
    parameter int  WIDTH = DEF_WIDTH,
    parameter int  DEPTH = DEF_DEPTH,
    localparam int IW    = idx_w(DEPTH),
    localparam int CW    = cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             flush,
    input  logic [WIDTH-1:0] pc_in,
    input  logic [IW-1:0]    rd_idx,
    output logic [WIDTH-1:0] newest,
    output logic [WIDTH-1:0] hist,
    output logic [CW-1:0]    count,
    output logic             full
);

    logic [WIDTH-1:0] ent [DEPTH];

    assign full = (count == CW'(DEPTH));

    // Entry storage: reset and flush clear everything, push shifts in pc_in.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
        end else if (push) begin
            for (int i = DEPTH - 1; i > 0; i--) ent[i] <= ent[i-1];
            ent[0] <= pc_in;
        end
    end

    // Occupancy count, saturating at DEPTH since the oldest entry is dropped.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            count <= '0;
        end else if (push && !full) begin
            count <= count + 1'b1;
        end
    end

    // Combinational reads; anything beyond the valid range reads as zero.
    always_comb begin
        hist   = '0;
        newest = '0;
        if (CW'(rd_idx) < count) hist = ent[rd_idx];
        if (count != '0)         newest = ent[0];
    end

endmodule

// File: rtl/pc_hist_unit.sv
// Program counter register with conditional write qualification and a
// history of previous PC values. Optional alignment check enabled by the
// macro PC_ALIGN_CHECK_EN: misaligned writes are dropped and flagged.
module pc_hist_unit
    import pc_pkg::*;
#(
    parameter int               WIDTH    = DEF_WIDTH,
    parameter int               DEPTH    = DEF_DEPTH,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEF_RESET_PC),
    localparam int              IW       = idx_w(DEPTH),
    localparam int              CW       = cnt_w(DEPTH)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             PCWr,
    input  logic             PCWrCond,
    input  logic             Cond,
    input  logic [WIDTH-1:0] PC_D,
    input  logic             PColdWr,
    input  logic             Flush,
    input  logic [IW-1:0]    Rd_Idx,
    output logic [WIDTH-1:0] PC_Q,
    output logic [WIDTH-1:0] PC_old_Q,
    output logic [WIDTH-1:0] PC_hist_Q,
    output logic [CW-1:0]    Count,
    output logic             Full,
    output logic             Misalign
);

    logic wr_req;
    logic wr_en;

    assign wr_req = PCWr | (PCWrCond & Cond);

`ifdef PC_ALIGN_CHECK_EN
    logic bad_align;

    assign bad_align = wr_req & (PC_D[1:0] != 2'b00);
    assign wr_en     = wr_req & ~bad_align;

    // Sticky misalignment flag, cleared only by reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            Misalign <= 1'b0;
        end else if (bad_align) begin
            Misalign <= 1'b1;
        end
    end
`else
    assign wr_en    = wr_req;
    assign Misalign = 1'b0;
`endif

    // PC register: loads PC_D on a qualified write, otherwise holds.
    always_ff @(posedge CLK) begin
        if (RST) begin
            PC_Q <= RESET_PC;
        end else if (wr_en) begin
            PC_Q <= PC_D;
        end
    end

    // History captures the pre-edge PC value on each push.
    pc_hist_buf #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_buf (
        .clk    (CLK),
        .rst    (RST),
        .push   (PColdWr),
        .flush  (Flush),
        .pc_in  (PC_Q),
        .rd_idx (Rd_Idx),
        .newest (PC_old_Q),
        .hist   (PC_hist_Q),
        .count  (Count),
        .full   (Full)
    );

endmodule

// File: tb/tb_pc_hist_unit.sv
// Directed self-checking bench for pc_hist_unit (WIDTH=32, DEPTH=4,
// RESET_PC=0x100). Alignment-check expectations follow PC_ALIGN_CHECK_EN.
module tb_pc_hist_unit;

    logic        CLK = 1'b0;
    logic        RST, PCWr, PCWrCond, Cond, PColdWr, Flush;
    logic [31:0] PC_D;
    logic [1:0]  Rd_Idx;
    logic [31:0] PC_Q, PC_old_Q, PC_hist_Q;
    logic [2:0]  Count;
    logic        Full, Misalign;

    int n_vec = 0;
    int n_bad = 0;

    pc_hist_unit #(
        .WIDTH    (32),
        .DEPTH    (4),
        .RESET_PC (32'h100)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .PCWr      (PCWr),
        .PCWrCond  (PCWrCond),
        .Cond      (Cond),
        .PC_D      (PC_D),
        .PColdWr   (PColdWr),
        .Flush     (Flush),
        .Rd_Idx    (Rd_Idx),
        .PC_Q      (PC_Q),
        .PC_old_Q  (PC_old_Q),
        .PC_hist_Q (PC_hist_Q),
        .Count     (Count),
        .Full      (Full),
        .Misalign  (Misalign)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle before sampling.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        RST = 0; PCWr = 0; PCWrCond = 0; Cond = 0; PColdWr = 0; Flush = 0;
        PC_D = 32'h0;
    endtask

    // Read a history entry through Rd_Idx and compare.
    task automatic chk_hist(input string tag, input logic [1:0] idx, input logic [31:0] exp);
        Rd_Idx = idx;
        #1;
        chk(tag, PC_hist_Q, exp);
    endtask

    initial begin
        idle();
        Rd_Idx = 2'd0;

        // Reset overrides a concurrent write and push.
        RST = 1; PCWr = 1; PC_D = 32'h55; PColdWr = 1;
        step();
        idle();
        chk("rst_pc",    PC_Q, 32'h100);
        chk("rst_count", 32'(Count), 32'd0);
        chk("rst_full",  32'(Full), 32'd0);
        chk("rst_old",   PC_old_Q, 32'h0);
        chk_hist("rst_hist", 2'd0, 32'h0);
        chk("rst_mis",   32'(Misalign), 32'd0);

        // Conditional write: blocked by Cond=0, taken with Cond=1.
        PCWrCond = 1; Cond = 0; PC_D = 32'h40;
        step();
        chk("cond0_hold", PC_Q, 32'h100);
        Cond = 1;
        step();
        chk("cond1_load", PC_Q, 32'h40);
        idle();

        // Push and write at the same edge: history gets the old PC.
        PCWr = 1; PC_D = 32'h10;
        step();
        chk("pc_10", PC_Q, 32'h10);
        PColdWr = 1; PC_D = 32'h14;
        step();
        idle();
        chk("pw_old",   PC_old_Q, 32'h10);
        chk("pw_pc",    PC_Q, 32'h14);
        chk("pw_count", 32'(Count), 32'd1);

        // Fill past DEPTH: push 0x0,0x4,0x8,0xC,0x10.
        Flush = 1;
        PCWr = 1; PC_D = 32'h0;
        step();
        chk("fl_count", 32'(Count), 32'd0);
        Flush = 0;
        for (int i = 1; i <= 5; i++) begin
            PColdWr = 1; PCWr = 1; PC_D = 32'(i * 4);
            step();
            if (i == 3) chk("fill3_count", 32'(Count), 32'd3);
            if (i == 4) chk("fill4_full",  32'(Full), 32'd1);
        end
        idle();
        chk("ovf_count", 32'(Count), 32'd4);
        chk("ovf_full",  32'(Full), 32'd1);
        chk("ovf_old",   PC_old_Q, 32'h10);
        chk("ovf_pc",    PC_Q, 32'h14);
        chk_hist("ovf_h0", 2'd0, 32'h10);
        chk_hist("ovf_h1", 2'd1, 32'hC);
        chk_hist("ovf_h2", 2'd2, 32'h8);
        chk_hist("ovf_h3", 2'd3, 32'h4);

        // Flush, then three pushes capturing 0x14,0x18,0x1C.
        Flush = 1;
        step();
        idle();
        for (int i = 0; i < 3; i++) begin
            PColdWr = 1; PCWr = 1; PC_D = 32'h18 + 32'(i * 4);
            step();
        end
        idle();
        chk("c3_count", 32'(Count), 32'd3);
        chk("c3_full",  32'(Full), 32'd0);
        chk("c3_old",   PC_old_Q, 32'h1C);
        chk_hist("c3_h2", 2'd2, 32'h14);
        chk_hist("c3_h3_invalid", 2'd3, 32'h0);

        // Flush wins over a simultaneous push; PC untouched.
        Flush = 1; PColdWr = 1;
        step();
        idle();
        chk("fp_count", 32'(Count), 32'd0);
        chk("fp_old",   PC_old_Q, 32'h0);
        chk("fp_pc",    PC_Q, 32'h20);
        chk_hist("fp_h0", 2'd0, 32'h0);

        // Misaligned write.
        PCWr = 1; PC_D = 32'h22;
        step();
        idle();
`ifdef PC_ALIGN_CHECK_EN
        chk("mis_pc",  PC_Q, 32'h20);
        chk("mis_flag", 32'(Misalign), 32'd1);
`else
        chk("mis_pc",  PC_Q, 32'h22);
        chk("mis_flag", 32'(Misalign), 32'd0);
`endif
        // Aligned write afterwards; flag is sticky when enabled.
        PCWr = 1; PC_D = 32'h24; PColdWr = 1;
        step();
        idle();
        chk("al_pc", PC_Q, 32'h24);
`ifdef PC_ALIGN_CHECK_EN
        chk("al_flag", 32'(Misalign), 32'd1);
`else
        chk("al_flag", 32'(Misalign), 32'd0);
`endif
        chk("al_count", 32'(Count), 32'd1);

        // Mid-operation reset clears everything.
        RST = 1; PCWr = 1; PC_D = 32'h80; PColdWr = 1;
        step();
        idle();
        chk("rst2_pc",    PC_Q, 32'h100);
        chk("rst2_count", 32'(Count), 32'd0);
        chk("rst2_old",   PC_old_Q, 32'h0);
        chk("rst2_mis",   32'(Misalign), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/pc_hist_unit.md
PC_HIST_UNIT -- requirements
Module: pc_hist_unit

Interface
REQ-001 Parameter WIDTH, default 32: PC and history entry width in bits.
REQ-002 Parameter DEPTH, default 4: number of history entries; legal range 2..16.
REQ-003 Parameter RESET_PC, default 0: PC_Q value after reset.
REQ-004 CLK  in  1  the single clock; all state updates on its rising edge.
REQ-005 RST  in  1  reset, synchronous, active-high.
REQ-006 PCWr  in  1  unconditional PC write enable.
REQ-007 PCWrCond  in  1  conditional PC write enable, qualified by Cond.
REQ-008 Cond  in  1  branch condition result.
REQ-009 PC_D  in  WIDTH  next-PC value.
REQ-010 PColdWr  in  1  push the current PC_Q into history.
REQ-011 Flush  in  1  clear the history.
REQ-012 Rd_Idx  in  IW=clog2(DEPTH)  history read index; 0 is the newest entry.
REQ-013 PC_Q  out  WIDTH  current PC.
REQ-014 PC_old_Q  out  WIDTH  newest history entry (entry 0).
REQ-015 PC_hist_Q  out  WIDTH  history entry selected by Rd_Idx.
REQ-016 Count  out  clog2(DEPTH+1)  number of valid history entries.
REQ-017 Full  out  1  high when Count==DEPTH.
REQ-018 Misalign  out  1  sticky misaligned-write flag.

Function
REQ-019 Write strobe W = PCWr | (PCWrCond & Cond); when W is high at an edge, PC_Q SHALL take PC_D the following cycle; otherwise PC_Q SHALL hold.
REQ-020 When PColdWr is high at an edge, the history SHALL shift: entry0<=PC_Q (the pre-edge value), entry i<=entry i-1, and Count SHALL increment, saturating at DEPTH.
REQ-021 When Full is high, a push SHALL discard the oldest entry (entry DEPTH-1) and leave Count at DEPTH.
REQ-022 When PColdWr and W are both high at the same edge, history SHALL capture the old PC and PC_Q SHALL take PC_D.
REQ-023 When Flush is high at an edge, all entries SHALL become 0 and Count SHALL become 0; Flush has priority over PColdWr and does not affect PC_Q.
REQ-024 PC_hist_Q and PC_old_Q SHALL be combinational reads of the stored entries.
REQ-025 When Rd_Idx >= Count, PC_hist_Q SHALL read 0.
REQ-026 When Count==0, PC_old_Q SHALL read 0.
REQ-027 Full and Count SHALL be registered-state-derived with zero-cycle latency.

Reset
REQ-028 When RST is high at an edge, the unit SHALL set PC_Q=RESET_PC, all entries=0, Count=0, and Misalign=0; RST overrides every other input, including a mid-operation W or PColdWr.
REQ-029 No initial-block values SHALL be relied on; all state SHALL be defined only by RST.

Configuration
REQ-030 Macro PC_ALIGN_CHECK_EN.
- Defined: a write with W=1 and PC_D[1:0]!=0 SHALL be suppressed, with PC_Q holding, and SHALL set Misalign.
- Misalign SHALL stay set until RST.
REQ-031 Macro PC_ALIGN_CHECK_EN undefined: all writes SHALL proceed regardless of PC_D[1:0], and Misalign SHALL be tied to 0.

Structure
REQ-032 Shared package pc_pkg SHALL hold:
- default WIDTH, DEPTH and RESET_PC constants;
- the index-width helper function;
- the PC word typedef.
REQ-033 The history shift buffer SHALL be a sub-module pc_hist_buf, with push, flush, index read, Count and Full; pc_hist_unit SHALL contain the PC register, write qualification and alignment check.

Verification
REQ-034 RST=1 for one edge with RESET_PC=0x100 -> PC_Q=0x100, Count=0, Full=0, PC_hist_Q=0.
REQ-035 PCWrCond=1, Cond=0, PC_D=0x40 -> PC_Q unchanged; then Cond=1 -> PC_Q=0x40 next cycle.
REQ-036 With PC_Q=0x10, assert PColdWr and PCWr together with PC_D=0x14 -> PC_old_Q=0x10, PC_Q=0x14, Count=1.
REQ-037 DEPTH=4: push 0x0,0x4,0x8,0xC,0x10 -> Count=4, Full=1, Rd_Idx=3 gives 0x4, and 0x0 is discarded.
REQ-038 Flush and PColdWr in the same cycle with Count=3 -> Count=0, PC_old_Q=0, PC_Q unchanged.
REQ-039 PC_ALIGN_CHECK_EN defined, PCWr=1, PC_D=0x22 -> PC_Q holds and Misalign=1; Misalign stays 1 after an aligned write; RST clears it.
